// File: rtl/msx_mouse_reader.sv
// msx_mouse_reader: host-side reader for the MSX joystick-port mouse.
// Drives the port strobe, waits HOLD_CYC cycles per nibble, samples four
// bit-reversed nibbles and rebuilds signed X/Y deltas plus buttons.
// Optional feature macro: MSX_MOUSE_ACCUM_EN adds saturating position
// accumulators on pos_x/pos_y; when undefined they are tied to zero.
module msx_mouse_reader #(
   parameter int HOLD_CYC = 64,
   parameter int ACC_W    = 10
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       port_in,
   output logic             strobe,
   output logic             busy,
   output logic             valid,
   output logic [7:0]       dx,
   output logic [7:0]       dy,
   output logic [1:0]       btn,
   output logic [ACC_W-1:0] pos_x,
   output logic [ACC_W-1:0] pos_y
);

   localparam int CNT_W = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TOG,
      S_WAIT,
      S_SAMP,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             strobe_q, strobe_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [7:0]       dx_q, dx_d;
   logic [7:0]       dy_q, dy_d;
   logic [1:0]       btn_q, btn_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      nib_q, nib_d;
   logic [1:0]       btn_s_q, btn_s_d;

   // The mouse shifts each nibble out LSB-first relative to the byte order
   function automatic logic [3:0] rev4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   // Next-state logic for the frame sequencer and its registered outputs
   always_comb begin
      state_d  = state_q;
      strobe_d = strobe_q;
      busy_d   = busy_q;
      valid_d  = 1'b0;
      dx_d     = dx_q;
      dy_d     = dy_q;
      btn_d    = btn_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      nib_d    = nib_q;
      btn_s_d  = btn_s_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_TOG;
               busy_d  = 1'b1;
               idx_d   = 2'd0;
            end
         end
         S_TOG: begin
            strobe_d = ~strobe_q;
            cnt_d    = CNT_W'(HOLD_CYC);
            state_d  = (HOLD_CYC == 0) ? S_SAMP : S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_SAMP;
            end
         end
         S_SAMP: begin
            nib_d[{idx_q, 2'b00} +: 4] = port_in[3:0];
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               // buttons are captured alongside the last nibble
               btn_s_d = ~port_in[5:4];
               state_d = S_DONE;
            end else begin
               state_d = S_TOG;
            end
         end
         S_DONE: begin
            dx_d    = {rev4(nib_q[3:0]),   rev4(nib_q[7:4])};
            dy_d    = {rev4(nib_q[11:8]),  rev4(nib_q[15:12])};
            btn_d   = btn_s_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and output registers; reset aborts any frame in progress
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q  <= S_IDLE;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         dx_q     <= 8'd0;
         dy_q     <= 8'd0;
         btn_q    <= 2'd0;
         idx_q    <= 2'd0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         strobe_q <= strobe_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         btn_q    <= btn_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
      end
   end

   // Nibble capture holding register; contents only matter once all four are in
   always_ff @(posedge clk_sys) begin
      nib_q   <= nib_d;
      btn_s_q <= btn_s_d;
   end

   assign strobe = strobe_q;
   assign busy   = busy_q;
   assign valid  = valid_q;
   assign dx     = dx_q;
   assign dy     = dy_q;
   assign btn    = btn_q;

`ifdef MSX_MOUSE_ACCUM_EN
   localparam logic signed [17:0] ACC_MAX = 18'((1 << (ACC_W - 1)) - 1);
   localparam logic signed [17:0] ACC_MIN = -ACC_MAX - 18'sd1;

   logic signed [ACC_W-1:0] pos_x_q, pos_x_d;
   logic signed [ACC_W-1:0] pos_y_q, pos_y_d;

   // Signed add clamped to the accumulator range instead of wrapping
   function automatic logic signed [ACC_W-1:0] sat_add(
      input logic signed [ACC_W-1:0] acc,
      input logic signed [7:0]       d
   );
      logic signed [17:0] sum;
      sum = 18'(acc) + 18'(d);
      if (sum > ACC_MAX) begin
         return ACC_W'(ACC_MAX);
      end else if (sum < ACC_MIN) begin
         return ACC_W'(ACC_MIN);
      end
      return ACC_W'(sum);
   endfunction

   // Accumulate the freshly assembled deltas on the edge that raises valid
   always_comb begin
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      if (valid_d) begin
         pos_x_d = sat_add(pos_x_q, $signed(dx_d));
         pos_y_d = sat_add(pos_y_q, $signed(dy_d));
      end
   end

   // Position registers cleared with the rest of the reader
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pos_x_q <= '0;
         pos_y_q <= '0;
      end else begin
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
      end
   end

   assign pos_x = pos_x_q;
   assign pos_y = pos_y_q;
`else
   assign pos_x = '0;
   assign pos_y = '0;
`endif

endmodule

// File: tb/tb_msx_mouse_reader.sv
// tb_msx_mouse_reader: directed bench for msx_mouse_reader.
// Two readers (HOLD_CYC=4 and HOLD_CYC=0) each face a strobe-toggle mouse model.
module tb_msx_mouse_reader;

   logic clk = 1'b0;
   logic reset;
   logic start_a, start_b;
   logic [5:0] port_a, port_b;
   logic strobe_a, busy_a, valid_a, strobe_b, busy_b, valid_b;
   logic [7:0] dx_a, dy_a, dx_b, dy_b;
   logic [1:0] btn_a, btn_b;
   logic signed [9:0] pos_x_a, pos_y_a, pos_x_b, pos_y_b;

   int n_chk = 0;
   int n_pass = 0;
   int tot_a = 0, tot_b = 0, base_a = 0, base_b = 0;
   logic [7:0] mx = 8'd0, my = 8'd0;
   logic [1:0] mb = 2'b11;

   always #5 clk = ~clk;

   msx_mouse_reader #(.HOLD_CYC(4), .ACC_W(10)) u_a (
      .clk_sys(clk), .reset(reset), .start(start_a), .port_in(port_a),
      .strobe(strobe_a), .busy(busy_a), .valid(valid_a),
      .dx(dx_a), .dy(dy_a), .btn(btn_a), .pos_x(pos_x_a), .pos_y(pos_y_a));

   msx_mouse_reader #(.HOLD_CYC(0), .ACC_W(10)) u_b (
      .clk_sys(clk), .reset(reset), .start(start_b), .port_in(port_b),
      .strobe(strobe_b), .busy(busy_b), .valid(valid_b),
      .dx(dx_b), .dy(dy_b), .btn(btn_b), .pos_x(pos_x_b), .pos_y(pos_y_b));

   // Mouse model: every strobe edge presents the next nibble, bits reversed
   function automatic logic [3:0] r4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   function automatic logic [3:0] nib(input int k, input logic [7:0] x, input logic [7:0] y);
      case (k)
         1: return r4(x[7:4]);
         2: return r4(x[3:0]);
         3: return r4(y[7:4]);
         4: return r4(y[3:0]);
         default: return 4'h0;
      endcase
   endfunction

   always @(strobe_a) tot_a++;
   always @(strobe_b) tot_b++;

   assign port_a = {mb, nib(tot_a - base_a, mx, my)};
   assign port_b = {mb, nib(tot_b - base_b, mx, my)};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Runs one frame on reader A (sb=0) or B (sb=1); lat = cycles from accept edge to valid
   task automatic frame(input bit sb, input logic [7:0] x, input logic [7:0] y,
                        input logic [1:0] pb, input bit hold, output int lat);
      bit got;
      @(negedge clk);
      mx = x; my = y; mb = pb;
      base_a = tot_a; base_b = tot_b;
      if (sb) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
      check("busy_after_accept", {31'd0, (sb ? busy_b : busy_a)}, 32'd1);
      lat = 0;
      got = 1'b0;
      for (int i = 1; i <= 300 && !got; i++) begin
         @(posedge clk); #1;
         if (sb ? valid_b : valid_a) begin
            lat = i;
            got = 1'b1;
         end
      end
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   initial begin
      int lat;
      int nv;
      logic s0;
      int exp_px [14];
      exp_px = '{127, 254, 381, 508, 511, 383, 255, 127, -1, -129, -257, -385, -512, -512};

      reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_strobe", {31'd0, strobe_a}, 32'd0);
      check("rst_busy",   {31'd0, busy_a},   32'd0);
      check("rst_valid",  {31'd0, valid_a},  32'd0);
      check("rst_dx_dy",  {16'd0, dx_a, dy_a}, 32'd0);
      check("rst_btn",    {30'd0, btn_a},    32'd0);
      check("rst_pos",    {12'd0, pos_x_a, pos_y_a}, 32'd0);
      @(negedge clk); reset = 1'b0;

      // Frame with wait states
      s0 = strobe_a;
      frame(1'b0, 8'h35, 8'hF0, 2'b10, 1'b0, lat);
      check("t1_latency", lat, 32'd25);
      check("t1_dx",  {24'd0, dx_a}, 32'h35);
      check("t1_dy",  {24'd0, dy_a}, 32'hF0);
      check("t1_btn", {30'd0, btn_a}, 32'h1);
      check("t1_edges", tot_a - base_a, 32'd4);
      check("t1_strobe_level", {31'd0, strobe_a}, {31'd0, s0});
      check("t1_busy_at_valid", {31'd0, busy_a}, 32'd0);

      // Frame with no wait states
      frame(1'b1, 8'h35, 8'hF0, 2'b10, 1'b0, lat);
      check("t2_latency", lat, 32'd9);
      check("t2_dx",  {24'd0, dx_b}, 32'h35);
      check("t2_dy",  {24'd0, dy_b}, 32'hF0);
      check("t2_btn", {30'd0, btn_b}, 32'h1);

      // start kept high throughout the frame: only one frame taken
      frame(1'b0, 8'h5A, 8'h03, 2'b01, 1'b1, lat);
      check("t3_latency", lat, 32'd25);
      check("t3_dx",  {24'd0, dx_a}, 32'h5A);
      check("t3_dy",  {24'd0, dy_a}, 32'h03);
      check("t3_btn", {30'd0, btn_a}, 32'h2);
      repeat (20) @(posedge clk);
      #1;
      check("t3_edges", tot_a - base_a, 32'd4);
      check("t3_busy_idle", {31'd0, busy_a}, 32'd0);

      // Reset during the wait of the third nibble
      @(negedge clk);
      mx = 8'h11; my = 8'h22; mb = 2'b11;
      base_a = tot_a;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      check("t4_edges_before_rst", tot_a - base_a, 32'd3);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check("t4_strobe", {31'd0, strobe_a}, 32'd0);
      check("t4_busy",   {31'd0, busy_a},   32'd0);
      check("t4_valid",  {31'd0, valid_a},  32'd0);
      check("t4_dx",     {24'd0, dx_a},     32'd0);
      @(negedge clk); reset = 1'b0;
      nv = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (valid_a) nv++;
      end
      check("t4_no_valid", nv, 32'd0);
      frame(1'b0, 8'h80, 8'h7F, 2'b11, 1'b0, lat);
      check("t4_latency", lat, 32'd25);
      check("t4_dx",  {24'd0, dx_a}, 32'h80);
      check("t4_dy",  {24'd0, dy_a}, 32'h7F);
      check("t4_btn", {30'd0, btn_a}, 32'h0);

      // Position accumulation (or its absence) over 14 frames on reader B
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      for (int f = 0; f < 14; f++) begin
         frame(1'b1, (f < 5) ? 8'h7F : 8'h80, 8'h00, 2'b11, 1'b0, lat);
`ifdef MSX_MOUSE_ACCUM_EN
         check("t5_pos_x", 32'(pos_x_b), exp_px[f]);
         check("t5_pos_y", 32'(pos_y_b), 32'd0);
`else
         check("t6_pos_x", 32'(pos_x_b), 32'd0);
         check("t6_pos_y", 32'(pos_y_b), 32'd0);
`endif
      end
      check("t5_last_dx", {24'd0, dx_b}, 32'h80);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
